// File: rtl/regfile_writeback.sv
// Purpose: merges ALU and long-latency results onto the single register-file write port, with a busy scoreboard.
// Latency: ALU result -> WE3 in 1 cycle; long-latency handshake -> WE3 in 2 cycles or more.
// Backpressure: ll_ready drops when the FIFO holds DEPTH entries; the ALU path is never stalled.

// Small generic FIFO: ready depends only on the registered count, so there is no valid->ready path.
module regfile_writeback_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   output logic             push_rdy,
   input  logic             pop_rdy,
   output logic             pop_vld,
   output logic [WIDTH-1:0] pop_dat
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   assign push_rdy = !rst && (count < CW'(DEPTH));
   assign pop_vld  = (count != '0);
   assign push     = push_vld && push_rdy;
   assign pop      = pop_rdy && pop_vld;
   assign pop_dat  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset; only entries covered by count are ever read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end
endmodule

module regfile_writeback #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_data,
   input  logic                     ll_valid,
   output logic                     ll_ready,
   input  logic [ADDRESS_WIDTH-1:0] ll_rd,
   input  logic [DATA_WIDTH-1:0]    ll_data,
   input  logic                     issue_valid,
   input  logic [ADDRESS_WIDTH-1:0] issue_rd,
   input  logic [ADDRESS_WIDTH-1:0] AD1,
   input  logic [ADDRESS_WIDTH-1:0] AD2,
   output logic                     hazard1,
   output logic                     hazard2,
   output logic                     WE3,
   output logic [ADDRESS_WIDTH-1:0] AD3,
   output logic [DATA_WIDTH-1:0]    WD3
);
   localparam int NREG = 2 ** ADDRESS_WIDTH;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    data;
   } ll_entry_t;

   ll_entry_t                    ll_in;
   ll_entry_t                    head;
   logic                         head_vld;
   logic                         head_pop;
   logic                         sel_vld;
   logic [ADDRESS_WIDTH-1:0]     sel_rd;
   logic [DATA_WIDTH-1:0]        sel_data;
   logic [NREG-1:0]              busy;
   logic [NREG-1:0]              busy_nxt;

   assign ll_in.rd   = ll_rd;
   assign ll_in.data = ll_data;

   regfile_writeback_fifo #(
      .WIDTH ($bits(ll_entry_t)),
      .DEPTH (DEPTH)
   ) u_ll_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (ll_valid),
      .push_dat (ll_in),
      .push_rdy (ll_ready),
      .pop_rdy  (!alu_valid),
      .pop_vld  (head_vld),
      .pop_dat  (head)
   );

   // ALU has strict priority; the FIFO head drains only in ALU bubbles.
   assign head_pop = !alu_valid && head_vld;
   assign sel_vld  = alu_valid || head_vld;
   assign sel_rd   = alu_valid ? alu_rd   : head.rd;
   assign sel_data = alu_valid ? alu_data : head.data;

   // Register the selected write; rd 0 still updates AD3/WD3 but never enables the write.
   always_ff @(posedge clk) begin
      if (rst) begin
         WE3 <= 1'b0;
         AD3 <= '0;
         WD3 <= '0;
      end else if (sel_vld) begin
         WE3 <= (sel_rd != '0);
         AD3 <= sel_rd;
         WD3 <= sel_data;
      end else begin
         WE3 <= 1'b0;
      end
   end

   // Scoreboard update: pop clears, a same-edge issue to the same rd wins, r0 is never busy.
   always_comb begin
      busy_nxt = busy;
      if (head_pop) busy_nxt[head.rd] = 1'b0;
      if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Busy vector register; reset discards every outstanding mark.
   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   assign hazard1 = busy[AD1];
   assign hazard2 = busy[AD2];
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ll_valid;
   logic        ll_ready;
   logic [4:0]  ll_rd;
   logic [31:0] ll_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  AD1;
   logic [4:0]  AD2;
   logic        hazard1;
   logic        hazard2;
   logic        WE3;
   logic [4:0]  AD3;
   logic [31:0] WD3;

   int checks = 0;
   int fails  = 0;

   regfile_writeback #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .AD1(AD1), .AD2(AD2), .hazard1(hazard1), .hazard2(hazard2),
      .WE3(WE3), .AD3(AD3), .WD3(WD3)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ll_valid = 0; ll_rd = 0; ll_data = 0;
      issue_valid = 0; issue_rd = 0;
   endtask

   task automatic chk_wr(input string name, input logic we, input logic [4:0] ad, input logic [31:0] wd);
      checks++;
      if (WE3 !== we || (we && (AD3 !== ad || WD3 !== wd))) begin
         fails++;
         $display("FAIL %s: got WE3=%b AD3=%0d WD3=%h, want WE3=%b AD3=%0d WD3=%h", name, WE3, AD3, WD3, we, ad, wd);
      end
   endtask

   task automatic test_reset;
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
         ll_valid = 1'($urandom); ll_rd = 5'($urandom); ll_data = $urandom;
         issue_valid = 1'($urandom); issue_rd = 5'($urandom);
         AD1 = 5'($urandom); AD2 = 5'($urandom);
         tick();
      end
      checks++;
      if (WE3 !== 1'b0 || AD3 !== 5'd0 || WD3 !== 32'd0) begin
         fails++;
         $display("FAIL reset_outputs: got WE3=%b AD3=%0d WD3=%h, want 0/0/0", WE3, AD3, WD3);
      end
      checks++;
      if (ll_ready !== 1'b0) begin fails++; $display("FAIL reset_ll_ready: got %b want 0", ll_ready); end
      idle_inputs();
      rst = 0;
      #1;
      checks++;
      if (ll_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ll_ready: got %b want 1", ll_ready); end
      tick();
      checks++;
      if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_hazard: got %b%b want 00", hazard1, hazard2);
      end
      chk_wr("post_reset_idle", 0, 0, 0);
   endtask

   task automatic test_alu_write;
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 0;
      chk_wr("alu_rd5", 1, 5, 32'hDEADBEEF);
      alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
      tick();
      alu_valid = 0;
      chk_wr("alu_rd0", 0, 0, 0);
      tick();
      chk_wr("alu_idle", 0, 0, 0);
   endtask

   task automatic test_priority_order;
      alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
      ll_valid = 1; ll_rd = 7; ll_data = 32'h11;
      tick();
      chk_wr("prio_alu1", 1, 1, 32'hA1);
      alu_rd = 2; alu_data = 32'hA2;
      ll_rd = 8; ll_data = 32'h22;
      checks++;
      if (ll_ready !== 1'b1) begin fails++; $display("FAIL prio_ready_one: got %b want 1", ll_ready); end
      tick();
      chk_wr("prio_alu2", 1, 2, 32'hA2);
      ll_valid = 0;
      alu_rd = 3; alu_data = 32'hA3;
      checks++;
      if (ll_ready !== 1'b0) begin fails++; $display("FAIL prio_ready_full: got %b want 0", ll_ready); end
      tick();
      chk_wr("prio_alu3", 1, 3, 32'hA3);
      alu_valid = 0;
      tick();
      chk_wr("prio_ll7", 1, 7, 32'h11);
      tick();
      chk_wr("prio_ll8", 1, 8, 32'h22);
      tick();
      chk_wr("prio_drained", 0, 0, 0);
   endtask

   task automatic test_scoreboard;
      AD1 = 9; AD2 = 0;
      issue_valid = 1; issue_rd = 9;
      tick();
      issue_valid = 0;
      checks++;
      if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin
         fails++;
         $display("FAIL sb_set: got hazard1=%b hazard2=%b want 1 0", hazard1, hazard2);
      end
      ll_valid = 1; ll_rd = 9; ll_data = 32'h99;
      tick();
      ll_valid = 0;
      checks++;
      if (hazard1 !== 1'b1) begin fails++; $display("FAIL sb_hold_after_push: got %b want 1", hazard1); end
      chk_wr("sb_no_write_yet", 0, 0, 0);
      tick();
      checks++;
      if (hazard1 !== 1'b0) begin fails++; $display("FAIL sb_clear_at_pop: got %b want 0", hazard1); end
      chk_wr("sb_write9", 1, 9, 32'h99);
      // Reissue rd 9 on the same edge its pending result pops: it must stay busy.
      issue_valid = 1; issue_rd = 9;
      tick();
      issue_valid = 0;
      ll_valid = 1; ll_rd = 9; ll_data = 32'h9A;
      tick();
      ll_valid = 0;
      issue_valid = 1; issue_rd = 9;
      checks++;
      if (hazard1 !== 1'b1) begin fails++; $display("FAIL sb_busy_before_pop: got %b want 1", hazard1); end
      tick();
      issue_valid = 0;
      chk_wr("sb_write9a", 1, 9, 32'h9A);
      checks++;
      if (hazard1 !== 1'b1) begin fails++; $display("FAIL sb_set_wins: got %b want 1", hazard1); end
      ll_valid = 1; ll_rd = 9; ll_data = 32'h9B;
      tick();
      ll_valid = 0;
      tick();
      chk_wr("sb_write9b", 1, 9, 32'h9B);
      checks++;
      if (hazard1 !== 1'b0) begin fails++; $display("FAIL sb_final_clear: got %b want 0", hazard1); end
   endtask

   task automatic test_full_wrap;
      logic [4:0]  q_rd [$];
      logic [31:0] q_dat [$];
      int cnt = 0;
      int pushed = 0;
      int ll_seen = 0;
      int cyc = 0;
      logic        exp_we;
      logic [4:0]  exp_ad;
      logic [31:0] exp_wd;
      logic        acc;
      while ((pushed < 10 || cnt > 0) && cyc < 60) begin
         alu_valid = (pushed < 10) ? 1'(cyc % 2 == 0) : 1'b0;
         alu_rd = 1; alu_data = 32'hA000 + 32'(cyc);
         ll_valid = (pushed < 10);
         ll_rd = 5'(10 + pushed); ll_data = 32'hC0 + 32'(pushed);
         #1;
         checks++;
         if (ll_ready !== (cnt < 2)) begin
            fails++;
            $display("FAIL wrap_ready cyc%0d: got %b want %b (count %0d)", cyc, ll_ready, cnt < 2, cnt);
         end
         acc = ll_valid && (cnt < 2);
         exp_we = 0; exp_ad = 0; exp_wd = 0;
         if (alu_valid) begin
            exp_we = 1; exp_ad = alu_rd; exp_wd = alu_data;
         end else if (cnt > 0) begin
            exp_we = 1; exp_ad = q_rd.pop_front(); exp_wd = q_dat.pop_front();
            cnt--;
            ll_seen++;
         end
         if (acc) begin
            q_rd.push_back(ll_rd); q_dat.push_back(ll_data);
            cnt++;
            pushed++;
         end
         tick();
         chk_wr($sformatf("wrap_cyc%0d", cyc), exp_we, exp_ad, exp_wd);
         cyc++;
      end
      idle_inputs();
      checks++;
      if (ll_seen != 10 || cyc >= 60) begin
         fails++;
         $display("FAIL wrap_total: got %0d ll writes in %0d cycles, want 10 within 60", ll_seen, cyc);
      end
      tick();
      chk_wr("wrap_idle", 0, 0, 0);
   endtask

   task automatic test_midop_reset;
      AD1 = 4;
      alu_valid = 1; alu_rd = 2; alu_data = 32'hB2;
      ll_valid = 1; ll_rd = 4; ll_data = 32'h44;
      issue_valid = 1; issue_rd = 4;
      tick();
      issue_valid = 0;
      ll_rd = 5; ll_data = 32'h55;
      tick();
      ll_valid = 0;
      alu_valid = 0;
      checks++;
      if (ll_ready !== 1'b0 || hazard1 !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre_reset: got ll_ready=%b hazard1=%b want 0 1", ll_ready, hazard1);
      end
      rst = 1;
      tick();
      rst = 0;
      chk_wr("mid_reset_edge", 0, 0, 0);
      #1;
      checks++;
      if (hazard1 !== 1'b0 || ll_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_after_reset: got hazard1=%b ll_ready=%b want 0 1", hazard1, ll_ready);
      end
      tick();
      chk_wr("mid_no_drain1", 0, 0, 0);
      tick();
      chk_wr("mid_no_drain2", 0, 0, 0);
   endtask

   initial begin
      idle_inputs();
      AD1 = 0; AD2 = 0;
      rst = 1;
      #1;
      test_reset();
      test_alu_write();
      test_priority_order();
      test_scoreboard();
      test_full_wrap();
      test_midop_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
